pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Control-side partner of the PLL wrapper: drives the PLL's RST input and qualifies its LOCK output.
//  Pulses PLL reset, waits for lock with a timeout and bounded retries, and debounces lock.
//  Releases the downstream system reset only after lock has been continuously stable.
//  Runs on the free-running PLL input clock (50 MHz board clock), not on any PLL output.
// PARAMETERS
//  RST_PULSE_CYC     16     cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT_CYC  50000  cycles allowed in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  LOCK_STABLE_CYC   1024   consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRY         4      timed-out attempts before FAIL (>=1)
//  CNT_W             20     shared counter width; must hold max(all *_CYC) - 1
// PORTS
//  clk          in   1      free-running reference clock (same net as PLL clkin1)
//  rst          in   1      synchronous, active-high reset
//  pll_lock     in   1      asynchronous LOCK from PLL; 2-flop synchronised internally
//  pll_rst      out  1      to PLL RST; high in RESET and FAIL states
//  sys_rst      out  1      downstream active-high reset; low only in RUN
//  locked_ok    out  1      high only in RUN
//  fail         out  1      high only in FAIL (sticky until rst)
//  retry_cnt    out  3      timed-out attempts since last rst or last entry to RUN
//  loss_cnt     out  8      lock-loss events seen in RUN (optional, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=RESET, cnt=0, retry_cnt=0, loss_cnt=0, sync flops=0.
//   Outputs in the rst cycle: pll_rst=1, sys_rst=1, locked_ok=0, fail=0.
//  All outputs are registered and decoded from the state register. Sync latency of pll_lock is 2 clk.
//  States:
//   RESET: pll_rst=1 for exactly RST_PULSE_CYC cycles (cnt 0..RST_PULSE_CYC-1).
//     Then cnt=0 -> WAIT_LOCK.
//   WAIT_LOCK: cnt increments each cycle.
//     lock_sync=1 -> STABLE, with stable counter =0. The timeout cnt is kept, not cleared.
//     cnt==LOCK_TIMEOUT_CYC-1 with lock_sync=0 -> retry_cnt+1.
//       If the new retry_cnt==MAX_RETRY -> FAIL; else -> RESET with cnt=0.
//   STABLE: stable counter increments while lock_sync=1. The timeout cnt keeps running.
//     Stable counter reaches LOCK_STABLE_CYC-1 -> RUN.
//     lock_sync=0 -> WAIT_LOCK (glitch; no PLL reset). Timeout still applies.
//     Timeout expiry in STABLE is handled exactly as in WAIT_LOCK.
//     Simultaneous stable-done and timeout: stable-done wins.
//   RUN: sys_rst=0, locked_ok=1. retry_cnt cleared on entry.
//     lock_sync=0 -> RESET, loss_cnt+1; sys_rst=1 and locked_ok=0 in the next cycle.
//   FAIL: pll_rst=1, sys_rst=1, fail=1. Exit only via rst.
//  retry_cnt never exceeds MAX_RETRY. Counters never wrap: every terminal compare forces a state change.
//  rst asserted mid-operation overrides everything and gives the reset values on the next edge.
// CONFIGURATION
//  `PLL_SUP_LOSS_COUNTER_EN defined: loss_cnt is an 8-bit counter, saturating at 255.
//    It increments once per RUN->RESET lock-loss transition and is cleared only by rst.
//  Not defined: loss_cnt is tied to 8'd0 and no counter logic is generated.
// TESTING (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=8, MAX_RETRY=2)
//  1. Clean lock: rst, then pll_lock=1 at cycle 10.
//     -> pll_rst high for cycles 1..4; locked_ok rises at cycle 10+2+8 (+/-1 per state edge, checked exactly).
//     -> sys_rst falls the same cycle locked_ok rises.
//  2. No lock ever.
//     -> two RESET pulses of 4 cycles, then FAIL: fail=1, pll_rst=1, retry_cnt=2. Holds for 1000 cycles.
//  3. Lock glitch in STABLE: lock drops 1 cycle after 5 stable cycles.
//     -> back to WAIT_LOCK, no pll_rst pulse.
//     -> after re-lock, 8 fresh stable cycles are needed before RUN.
//  4. Loss in RUN: deassert pll_lock.
//     -> 2 cycles later state RESET, sys_rst=1, pll_rst pulses 4 cycles.
//     -> loss_cnt=1 with macro, 0 without. retry_cnt=0.
//  5. Late lock: lock first appears at WAIT_LOCK cycle 95 and stays.
//     -> timeout at cycle 99 in STABLE, retry_cnt=1, RESET. Relock then succeeds and retry_cnt clears in RUN.
//  6. rst asserted in STABLE and in FAIL.
//     -> next cycle all outputs at reset values; the sequence restarts from RESET.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier: pulses PLL reset, waits for a debounced lock, retries on
// timeout and releases sys_rst only in RUN. Define PLL_SUP_LOSS_COUNTER_EN to count lock losses.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 4,
    parameter int unsigned CNT_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked_ok,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [2:0]       MaxRetry    = 3'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [2:0]       retry_q, retry_d;
    logic [1:0]       sync_q, sync_d;

    logic       lock_sync;
    logic       timeout;
    logic [2:0] retry_next;

    assign sync_d     = {sync_q[0], pll_lock};
    assign lock_sync  = sync_q[1];
    assign timeout    = (cnt_q == TimeoutLast);
    assign retry_next = retry_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        unique case (state_q)
            StReset: begin
                if (cnt_q == PulseLast) begin
                    cnt_d   = '0;
                    state_d = StWaitLock;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (lock_sync) begin
                    state_d = StStable;
                    stab_d  = '0;
                    // Hold at the terminal value so STABLE still sees the expiry.
                    cnt_d   = timeout ? cnt_q : cnt_q + 1'b1;
                end else if (timeout) begin
                    retry_d = retry_next;
                    cnt_d   = '0;
                    state_d = (retry_next == MaxRetry) ? StFail : StReset;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStable: begin
                if (lock_sync && stab_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (timeout) begin
                    retry_d = retry_next;
                    cnt_d   = '0;
                    state_d = (retry_next == MaxRetry) ? StFail : StReset;
                end else if (!lock_sync) begin
                    state_d = StWaitLock;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_sync) begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReset;
            cnt_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
            sync_q  <= sync_d;
        end
    end

    always_comb begin
        pll_rst   = (state_q == StReset) || (state_q == StFail);
        sys_rst   = (state_q != StRun);
        locked_ok = (state_q == StRun);
        fail      = (state_q == StFail);
        retry_cnt = retry_q;
    end

`ifdef PLL_SUP_LOSS_COUNTER_EN
    logic [7:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == StRun && !lock_sync && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
